feature_map_writer: RTL and testbench

Sink for the convolutional layer's valid-qualified output stream. It captures one complete output feature map of (IMAGE_WIDTH-FILTER_SIZE+1) x (IMAGE_HEIGHT-FILTER_SIZE+1) multi-channel pixels, in raster order, into an internal buffer. It raises `frame_done` once the map is complete and lets a host or the next layer read pixels back by address. It sits directly behind `convolutional_layer` and shares its `clk_en` gating.

---
 rtl/feature_map_writer.sv | 162 ++++++++++++++++
 tb/tb_feature_map_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_map_writer.sv
// ---------------------------------------------------------------------------
// feature_map_writer
//   Captures one output feature map of the upstream convolutional layer
//   (OUT_W x OUT_H multi-channel pixels, raster order) into an internal
//   buffer. It raises frame_done when the map is complete. The buffer can be
//   read back by raster address at any time.
//
// Optional feature macro: FEATURE_MAP_RELU_EN
//   When defined, each channel is treated as two's complement and negative
//   values are stored as zero. This adds no extra latency.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   clk_en           global enable; when low, all state and outputs hold
//   start            arms capture of a new frame (ignored while capturing)
//   input_data/valid pixel stream, channel 0 in the MSBs, no backpressure
//   rd_en/rd_addr    read request, address = row*OUT_W+col
//   rd_data/rd_valid read response, one-cycle latency (zero when addr >= DEPTH)
//   capturing        FSM is in CAPTURE
//   frame_done       a complete frame is held in the buffer
//   overflow         sticky: a valid pixel was dropped outside capture
//   pixel_count      pixels written in the current frame
// ---------------------------------------------------------------------------
module feature_map_writer #(
    parameter int Q_WIDTH      = 16,
    parameter int Q_CHANNELS   = 3,
    parameter int FILTER_SIZE  = 2,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    localparam int OUT_W = IMAGE_WIDTH - FILTER_SIZE + 1,
    localparam int OUT_H = IMAGE_HEIGHT - FILTER_SIZE + 1,
    localparam int DEPTH = OUT_W * OUT_H,
    localparam int AW    = $clog2(DEPTH),
    localparam int DW    = Q_CHANNELS * Q_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          start,
    input  logic [DW-1:0] input_data,
    input  logic          input_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          capturing,
    output logic          frame_done,
    output logic          overflow,
    output logic [AW:0]   pixel_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row;
    logic [AW:0]   r_cnt;
    logic          r_frame_done;
    logic          r_overflow;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_arm;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_col;
    logic [AW-1:0] w_row;
    logic [AW:0]   w_cnt;
    logic          w_last;
    logic          w_rd_in_range;
    logic [DW-1:0] w_wdata;

    // A start outside CAPTURE re-arms the frame. A pixel arriving in the same
    // cycle becomes pixel 0 of the new frame, so the write position is taken
    // from the cleared values rather than the stale counters.
    assign w_arm   = (r_state != CAPTURE) && start;
    assign w_we    = input_valid && ((r_state == CAPTURE) || w_arm);
    assign w_waddr = w_arm ? '0 : r_addr;
    assign w_col   = w_arm ? '0 : r_col;
    assign w_row   = w_arm ? '0 : r_row;
    assign w_cnt   = w_arm ? '0 : r_cnt;
    assign w_last  = (w_row == AW'(OUT_H - 1)) && (w_col == AW'(OUT_W - 1));

    // Widened compare so that a DEPTH equal to 2**AW cannot wrap to zero.
    assign w_rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));

    always_comb begin
        w_wdata = input_data;
`ifdef FEATURE_MAP_RELU_EN
        for (int c = 0; c < Q_CHANNELS; c++) begin
            if (input_data[c*Q_WIDTH + Q_WIDTH - 1])
                w_wdata[c*Q_WIDTH +: Q_WIDTH] = '0;
        end
`endif
    end

    // The buffer has no reset. Its contents survive a reset mid-frame.
    always_ff @(posedge clk) begin
        if (clk_en && w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else if (clk_en) begin
            // Non-blocking read of r_mem gives read-first behaviour when the
            // read and write target the same address.
            r_rd_valid <= rd_en;
            if (rd_en)
                r_rd_data <= w_rd_in_range ? r_mem[rd_addr] : '0;

            if (w_arm) begin
                r_state      <= CAPTURE;
                r_addr       <= '0;
                r_col        <= '0;
                r_row        <= '0;
                r_cnt        <= '0;
                r_frame_done <= 1'b0;
                r_overflow   <= 1'b0;
            end else if (input_valid && (r_state != CAPTURE)) begin
                r_overflow <= 1'b1;
            end

            // These assignments come after the arm clears, so they win.
            if (w_we) begin
                r_cnt  <= w_cnt + 1'b1;
                r_addr <= w_waddr + 1'b1;
                if (w_col == AW'(OUT_W - 1)) begin
                    r_col <= '0;
                    r_row <= w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                if (w_last) begin
                    r_state      <= DONE;
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign capturing   = (r_state == CAPTURE);
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign pixel_count = r_cnt;

endmodule

// File: tb/tb_feature_map_writer.sv
module tb_feature_map_writer;
    localparam int QW    = 16;
    localparam int DW    = 3 * QW;
    localparam int DEPTH = 1953;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          reset, clk_en, start, input_valid, rd_en;
    logic [DW-1:0] input_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid, capturing, frame_done, overflow;
    logic [AW:0]   pixel_count;

    int checks = 0;
    int errors = 0;

    feature_map_writer dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .input_data(input_data), .input_valid(input_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .capturing(capturing), .frame_done(frame_done), .overflow(overflow),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    // Inputs change, and outputs are sampled, 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pix(input int v);
        logic [QW-1:0] a, b, c;
        a = QW'(v); b = QW'(v + 1); c = QW'(v + 2);
        return {a, b, c};
    endfunction

    task automatic do_read(input int addr);
        rd_en = 1'b1; rd_addr = AW'(addr);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; input_valid = 1'b0;
        input_data = '0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({rd_data, rd_valid, capturing, frame_done, overflow, pixel_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: rd_data=%h rd_valid=%b cap=%b done=%b ovf=%b cnt=%0d expected all 0",
                     rd_data, rd_valid, capturing, frame_done, overflow, pixel_count);
        end
    endtask

    task automatic test_capture();
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (capturing !== 1'b1) begin errors++; $display("FAIL start_capturing: got %b expected 1", capturing); end
        for (int i = 0; i < DEPTH; i++) begin
            input_valid = 1'b1; input_data = pix(i);
            if (i == DEPTH - 1) begin
                checks++;
                if (frame_done !== 1'b0 || pixel_count !== (AW+1)'(DEPTH - 1)) begin
                    errors++;
                    $display("FAIL done_early: done=%b cnt=%0d expected 0/%0d", frame_done, pixel_count, DEPTH - 1);
                end
            end
            tick();
        end
        input_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || pixel_count !== (AW+1)'(DEPTH) || overflow !== 1'b0 || capturing !== 1'b0) begin
            errors++;
            $display("FAIL frame_complete: done=%b cnt=%0d ovf=%b cap=%b expected 1/%0d/0/0",
                     frame_done, pixel_count, overflow, capturing, DEPTH);
        end
    endtask

    task automatic test_read();
        int addrs [4] = '{0, 62, 63, 1952};
        for (int k = 0; k < 4; k++) begin
            do_read(addrs[k]);
            checks++;
            if (rd_data !== pix(addrs[k]) || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL read_addr_%0d: got %h/%b expected %h/1", addrs[k], rd_data, rd_valid, pix(addrs[k]));
            end
        end
        do_read(DEPTH);
        checks++;
        if (rd_data !== '0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_out_of_range: got %h/%b expected 0/1", rd_data, rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_idle: got %b expected 0", rd_valid); end
    endtask

    task automatic test_overflow();
        input_valid = 1'b1; input_data = {3{16'hBEEF}};
        tick();
        input_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || frame_done !== 1'b1 || pixel_count !== (AW+1)'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_in_done: ovf=%b done=%b cnt=%0d expected 1/1/%0d", overflow, frame_done, pixel_count, DEPTH);
        end
        do_read(0);
        checks++;
        if (rd_data !== pix(0)) begin errors++; $display("FAIL data_after_overflow: got %h expected %h", rd_data, pix(0)); end
    endtask

    task automatic test_start_with_valid();
        // Start and a valid pixel together, taken from DONE: pixel 0, overflow cleared.
        start = 1'b1; input_valid = 1'b1; input_data = pix(500);
        tick();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || frame_done !== 1'b0 || capturing !== 1'b1 || pixel_count !== 12'd1) begin
            errors++;
            $display("FAIL start_with_valid: ovf=%b done=%b cap=%b cnt=%0d expected 0/0/1/1",
                     overflow, frame_done, capturing, pixel_count);
        end
        // Write addr 1 while reading addr 1: the read returns the old pixel.
        input_data = pix(600); rd_en = 1'b1; rd_addr = 11'd1;
        tick();
        input_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_data !== pix(1)) begin errors++; $display("FAIL read_first: got %h expected %h", rd_data, pix(1)); end
        do_read(0);
        checks++;
        if (rd_data !== pix(500)) begin errors++; $display("FAIL pixel0_new_frame: got %h expected %h", rd_data, pix(500)); end
        do_read(1);
        checks++;
        if (rd_data !== pix(600)) begin errors++; $display("FAIL write_then_read: got %h expected %h", rd_data, pix(600)); end
    endtask

    task automatic test_ignore_start();
        start = 1'b1; input_valid = 1'b1; input_data = pix(700);
        tick();
        start = 1'b0; input_valid = 1'b0;
        checks++;
        if (pixel_count !== 12'd3 || capturing !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL start_in_capture: cnt=%0d cap=%b ovf=%b expected 3/1/0", pixel_count, capturing, overflow);
        end
        do_read(2);
        checks++;
        if (rd_data !== pix(700)) begin errors++; $display("FAIL addr2_after_start: got %h expected %h", rd_data, pix(700)); end
    endtask

    task automatic test_reset_mid();
        for (int i = 3; i < 100; i++) begin
            input_valid = 1'b1; input_data = pix(i);
            tick();
        end
        input_valid = 1'b0;
        checks++;
        if (pixel_count !== 12'd100) begin errors++; $display("FAIL count_100: got %0d expected 100", pixel_count); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({rd_data, rd_valid, capturing, frame_done, overflow, pixel_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame: rd_data=%h rd_valid=%b cap=%b done=%b ovf=%b cnt=%0d expected all 0",
                     rd_data, rd_valid, capturing, frame_done, overflow, pixel_count);
        end
    endtask

    task automatic test_clk_en();
        int written = 0;
        int cyc = 0;
        start = 1'b1; tick(); start = 1'b0;
        while (written < DEPTH && cyc < 3 * DEPTH) begin
            clk_en = (cyc % 2 == 0);
            input_valid = 1'b1;
            input_data = clk_en ? pix(written + 7) : {3{16'hDEAD}};
            if (written == DEPTH - 1 && clk_en) begin
                checks++;
                if (frame_done !== 1'b0) begin errors++; $display("FAIL clk_en_done_early: got %b expected 0", frame_done); end
            end
            tick();
            if (clk_en) written++;
            checks++;
            if (pixel_count !== (AW+1)'(written)) begin
                errors++;
                $display("FAIL clk_en_count cycle %0d: got %0d expected %0d", cyc, pixel_count, written);
            end
            cyc++;
        end
        input_valid = 1'b0; clk_en = 1'b1;
        checks++;
        if (frame_done !== 1'b1 || written != DEPTH) begin
            errors++;
            $display("FAIL clk_en_frame_done: done=%b written=%0d expected 1/%0d", frame_done, written, DEPTH);
        end
        do_read(10);
        checks++;
        if (rd_data !== pix(17)) begin errors++; $display("FAIL clk_en_addr10: got %h expected %h", rd_data, pix(17)); end
        // Read request with clk_en low must not launch; outputs hold.
        clk_en = 1'b0; rd_en = 1'b1; rd_addr = 11'd20;
        tick();
        clk_en = 1'b1; rd_en = 1'b0;
        checks++;
        if (rd_data !== pix(17) || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL clk_en_low_read_hold: got %h/%b expected %h/1", rd_data, rd_valid, pix(17));
        end
        do_read(1952);
        checks++;
        if (rd_data !== pix(1959)) begin errors++; $display("FAIL clk_en_addr1952: got %h expected %h", rd_data, pix(1959)); end
    endtask

    task automatic test_relu();
        logic [DW-1:0] exp_d;
        start = 1'b1; input_valid = 1'b1; input_data = {16'hFFF0, 16'h7FFF, 16'h8000};
        tick();
        start = 1'b0; input_valid = 1'b0;
`ifdef FEATURE_MAP_RELU_EN
        exp_d = {16'h0000, 16'h7FFF, 16'h0000};
`else
        exp_d = {16'hFFF0, 16'h7FFF, 16'h8000};
`endif
        do_read(0);
        checks++;
        if (rd_data !== exp_d) begin errors++; $display("FAIL relu_store: got %h expected %h", rd_data, exp_d); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_read();
        test_overflow();
        test_start_with_valid();
        test_ignore_start();
        test_reset_mid();
        test_clk_en();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
